arp_binding_table_ctrl: RTL

- Owns the shared IP→MAC binding table used for ARP spoof detection.
- Arbitrates three requesters: the frame parser's lookup/learn request, host static-config writes, and a periodic aging scrubber.
- Sequences every table operation as a one-entry-per-cycle scan, then a single write.
- Drives the sticky spoof alert and exports the offending IP/MAC pair.

---
 rtl/arp_tbl_pkg.sv | 36 +++
 rtl/arp_tbl_scan.sv | 60 ++++++
 rtl/arp_binding_table_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/arp_tbl_pkg.sv
// Shared types and defaults for the ARP IP->MAC binding table controller.
package arp_tbl_pkg;

   localparam int unsigned DEPTH_DEF   = 32;
   localparam int unsigned AGE_W_DEF   = 4;
   localparam int unsigned MAX_AGE_DEF = 15;
   localparam int unsigned AGE_W_MAX   = 8;
   localparam int unsigned IP_W        = 32;
   localparam int unsigned MAC_W       = 48;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SCAN_REQ,
      ST_SCAN_CFG,
      ST_SCAN_AGE,
      ST_COMMIT
   } state_e;

   typedef enum logic [2:0] {
      RC_NONE,
      RC_HIT,
      RC_SPOOF,
      RC_LEARN,
      RC_FULL
   } resp_code_e;

   // Age field is sized for the widest supported AGE_W; only AGE_W low bits ever become nonzero.
   typedef struct packed {
      logic                 valid;
      logic                 is_static;
      logic [IP_W-1:0]      ip;
      logic [MAC_W-1:0]     mac;
      logic [AGE_W_MAX-1:0] age;
   } entry_t;

endpackage

// File: rtl/arp_tbl_scan.sv
// Linear-scan tracker: remembers the lowest matching and lowest free index seen so far.
module arp_tbl_scan
   import arp_tbl_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             en,
   input  logic [IDX_W-1:0] idx,
   input  logic             ent_valid,
   input  logic [IP_W-1:0]  ent_ip,
   input  logic [IP_W-1:0]  key_ip,
   output logic             hit_c,
   output logic [IDX_W-1:0] hit_idx_c,
   output logic             free_c,
   output logic [IDX_W-1:0] free_idx_c,
   output logic             done_c
);

   logic             hit_q;
   logic             free_q;
   logic [IDX_W-1:0] hit_idx_q;
   logic [IDX_W-1:0] free_idx_q;
   logic             cur_hit;
   logic             cur_free;

   // Results including the entry presented this cycle, so the last index is usable at once.
   always_comb begin
      cur_hit    = ent_valid && (ent_ip == key_ip);
      cur_free   = !ent_valid;
      hit_c      = hit_q || cur_hit;
      hit_idx_c  = hit_q ? hit_idx_q : idx;
      free_c     = free_q || cur_free;
      free_idx_c = free_q ? free_idx_q : idx;
      done_c     = en && (idx == IDX_W'(DEPTH - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_q      <= 1'b0;
         free_q     <= 1'b0;
         hit_idx_q  <= '0;
         free_idx_q <= '0;
      end else if (clear) begin
         hit_q      <= 1'b0;
         free_q     <= 1'b0;
         hit_idx_q  <= '0;
         free_idx_q <= '0;
      end else if (en) begin
         hit_q      <= hit_c;
         hit_idx_q  <= hit_idx_c;
         free_q     <= free_c;
         free_idx_q <= free_idx_c;
      end
   end

endmodule

// File: rtl/arp_binding_table_ctrl.sv
// IP->MAC binding table owner: arbitrates parser lookups, host static writes and aging sweeps,
// each run as a full linear scan followed by a single commit.
module arp_binding_table_ctrl
   import arp_tbl_pkg::*;
#(
   parameter int unsigned DEPTH   = DEPTH_DEF,
   parameter int unsigned IDX_W   = $clog2(DEPTH),
   parameter int unsigned AGE_W   = AGE_W_DEF,
   parameter int unsigned MAX_AGE = MAX_AGE_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [31:0]       req_ip,
   input  logic [47:0]       req_mac,
   output logic              resp_valid,
   output logic              resp_hit,
   output logic              resp_mismatch,
   output logic              resp_learned,
   output logic              resp_full,
   input  logic              cfg_wr,
   input  logic [31:0]       cfg_ip,
   input  logic [47:0]       cfg_mac,
   output logic              cfg_done,
   output logic              cfg_err,
   input  logic              age_tick,
   input  logic              alert_clr,
   output logic              alert,
   output logic [31:0]       ip_addr_export,
   output logic [47:0]       mac_addr_export,
   output logic [IDX_W:0]    entry_count
);

   localparam int unsigned CNT_W = IDX_W + 1;

   state_e           state;
   entry_t           tbl [DEPTH];
   logic [IDX_W-1:0] idx_q;
   logic [IP_W-1:0]  key_ip_q;
   logic [MAC_W-1:0] key_mac_q;
   logic             age_pending;

   logic             commit_wr;
   logic             commit_inc;
   logic             commit_spoof;
   logic [IDX_W-1:0] commit_idx;
   entry_t           commit_ent;

   logic             scanning_c;
   logic             hit_c;
   logic             free_c;
   logic             done_c;
   logic [IDX_W-1:0] hit_idx_c;
   logic [IDX_W-1:0] free_idx_c;
   entry_t           hit_ent_c;
   resp_code_e       code_c;
   logic             wr_c;
   logic             inc_c;
   logic [IDX_W-1:0] wr_idx_c;
   entry_t           wr_ent_c;

   assign scanning_c = (state == ST_SCAN_REQ) || (state == ST_SCAN_CFG) || (state == ST_SCAN_AGE);
   assign req_ready  = (state == ST_IDLE) && !cfg_wr;

   arp_tbl_scan #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_scan (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (!scanning_c),
      .en         (scanning_c),
      .idx        (idx_q),
      .ent_valid  (tbl[idx_q].valid),
      .ent_ip     (tbl[idx_q].ip),
      .key_ip     (key_ip_q),
      .hit_c      (hit_c),
      .hit_idx_c  (hit_idx_c),
      .free_c     (free_c),
      .free_idx_c (free_idx_c),
      .done_c     (done_c)
   );

   // Outcome of the scan as seen on its final cycle, plus the write it implies.
   always_comb begin
      hit_ent_c = tbl[hit_idx_c];
      code_c    = RC_NONE;
      wr_c      = 1'b0;
      inc_c     = 1'b0;
      wr_idx_c  = free_idx_c;
      wr_ent_c  = '0;
      case (state)
         ST_SCAN_REQ: begin
            if (hit_c) begin
               if (hit_ent_c.mac == key_mac_q) begin
                  code_c       = RC_HIT;
                  wr_c         = !hit_ent_c.is_static;
                  wr_idx_c     = hit_idx_c;
                  wr_ent_c     = hit_ent_c;
                  wr_ent_c.age = '0;
               end else begin
                  code_c = RC_SPOOF;
               end
            end else if (free_c) begin
               code_c             = RC_LEARN;
               wr_c               = 1'b1;
               inc_c              = 1'b1;
               wr_ent_c.valid     = 1'b1;
               wr_ent_c.is_static = 1'b0;
               wr_ent_c.ip        = key_ip_q;
               wr_ent_c.mac       = key_mac_q;
            end else begin
               code_c = RC_FULL;
            end
         end
         ST_SCAN_CFG: begin
            if (hit_c || free_c) begin
               wr_c               = 1'b1;
               inc_c              = !hit_c;
               wr_idx_c           = hit_c ? hit_idx_c : free_idx_c;
               wr_ent_c.valid     = 1'b1;
               wr_ent_c.is_static = 1'b1;
               wr_ent_c.ip        = key_ip_q;
               wr_ent_c.mac       = key_mac_q;
            end else begin
               code_c = RC_FULL;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_IDLE;
         idx_q           <= '0;
         key_ip_q        <= '0;
         key_mac_q       <= '0;
         age_pending     <= 1'b0;
         commit_wr       <= 1'b0;
         commit_inc      <= 1'b0;
         commit_spoof    <= 1'b0;
         commit_idx      <= '0;
         commit_ent      <= '0;
         resp_valid      <= 1'b0;
         resp_hit        <= 1'b0;
         resp_mismatch   <= 1'b0;
         resp_learned    <= 1'b0;
         resp_full       <= 1'b0;
         cfg_done        <= 1'b0;
         cfg_err         <= 1'b0;
         alert           <= 1'b0;
         ip_addr_export  <= '0;
         mac_addr_export <= '0;
         entry_count     <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            tbl[i] <= '0;
         end
      end else begin
         resp_valid    <= 1'b0;
         resp_hit      <= 1'b0;
         resp_mismatch <= 1'b0;
         resp_learned  <= 1'b0;
         resp_full     <= 1'b0;
         cfg_done      <= 1'b0;
         cfg_err       <= 1'b0;
         if (age_tick) begin
            age_pending <= 1'b1;
         end
         if (alert_clr) begin
            alert <= 1'b0;
         end
         case (state)
            ST_IDLE: begin
               idx_q <= '0;
               if (cfg_wr) begin
                  key_ip_q  <= cfg_ip;
                  key_mac_q <= cfg_mac;
                  state     <= ST_SCAN_CFG;
               end else if (req_valid) begin
                  key_ip_q  <= req_ip;
                  key_mac_q <= req_mac;
                  state     <= ST_SCAN_REQ;
               end else if (age_pending) begin
                  age_pending <= age_tick;
                  state       <= ST_SCAN_AGE;
               end
            end
            ST_SCAN_REQ, ST_SCAN_CFG, ST_SCAN_AGE: begin
               idx_q <= idx_q + IDX_W'(1);
               // Aging is applied in place as the sweep passes each dynamic entry.
               if (state == ST_SCAN_AGE && tbl[idx_q].valid && !tbl[idx_q].is_static) begin
                  if (tbl[idx_q].age[AGE_W-1:0] == AGE_W'(MAX_AGE)) begin
                     tbl[idx_q].valid <= 1'b0;
                     entry_count      <= entry_count - CNT_W'(1);
                  end else begin
                     tbl[idx_q].age <= AGE_W_MAX'(tbl[idx_q].age[AGE_W-1:0] + AGE_W'(1));
                  end
               end
               if (done_c) begin
                  state        <= ST_COMMIT;
                  commit_wr    <= wr_c;
                  commit_inc   <= inc_c;
                  commit_idx   <= wr_idx_c;
                  commit_ent   <= wr_ent_c;
                  commit_spoof <= (code_c == RC_SPOOF);
                  if (state == ST_SCAN_REQ) begin
                     resp_valid    <= 1'b1;
                     resp_hit      <= (code_c == RC_HIT) || (code_c == RC_SPOOF);
                     resp_mismatch <= (code_c == RC_SPOOF);
                     resp_learned  <= (code_c == RC_LEARN);
                     resp_full     <= (code_c == RC_FULL);
                  end
                  if (state == ST_SCAN_CFG) begin
                     cfg_done <= 1'b1;
                     cfg_err  <= (code_c == RC_FULL);
                  end
               end
            end
            ST_COMMIT: begin
               state <= ST_IDLE;
               if (commit_wr) begin
                  tbl[commit_idx] <= commit_ent;
                  entry_count     <= entry_count + CNT_W'(commit_inc);
               end
               // A new spoof overrides a same-cycle clear.
               if (commit_spoof) begin
                  alert           <= 1'b1;
                  ip_addr_export  <= key_ip_q;
                  mac_addr_export <= key_mac_q;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
